// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared codes, FSM states and per-op step rules for the FPU op sequencer
package fpu_seq_pkg;
  localparam logic [1:0] SRC_GPR  = 2'b00;
  localparam logic [1:0] SRC_ONE  = 2'b01;
  localparam logic [1:0] SRC_XMM  = 2'b10;
  localparam logic [1:0] SRC_NXMM = 2'b11;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_CVT  = 2'b01;
  localparam logic [1:0] OP_DOT3 = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_RESP} state_t;
  function automatic logic [1:0] op_steps(input logic [1:0] op);
    return op == OP_DOT3 ? 2'd3 : op == OP_SUB ? 2'd2 : 2'd1;
  endfunction
  function automatic logic [1:0] sel_a(input logic [1:0] op, input logic [1:0] step);
    return op == OP_CVT ? SRC_GPR : (op == OP_SUB && step == 2'd1) ? SRC_NXMM : SRC_XMM;
  endfunction
  function automatic logic [1:0] sel_b(input logic [1:0] op);
    return (op == OP_CVT || op == OP_SUB) ? SRC_ONE : SRC_XMM;
  endfunction
endpackage

// File: rtl/fpu_seq_acc.sv
// fpu_seq_acc: result accumulator with clear/add; FPU_SEQ_SAT_EN makes the add saturate
module fpu_seq_acc #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_val,
  output logic [DATA_W-1:0] o_next
);
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_add;
  assign w_sum = r_acc + i_val;
`ifdef FPU_SEQ_SAT_EN
  logic w_ovf;
  assign w_ovf = (r_acc[DATA_W-1] == i_val[DATA_W-1]) && (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_add = w_ovf ? {r_acc[DATA_W-1], {(DATA_W-1){~r_acc[DATA_W-1]}}} : w_sum;
`else
  assign w_add = w_sum;
`endif
  assign o_next = i_clr ? '0 : i_add ? w_add : r_acc;
  // accumulator register; next value is exposed so the response can capture a same-cycle result
  always_ff @(posedge clk)
    if (reset) r_acc <= '0;
    else r_acc <= o_next;
endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues multi-step FPU macro-ops and returns the accumulated result (option FPU_SEQ_SAT_EN)
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int XMM_IDX_W      = 3,
  parameter int DATA_W         = 64,
  parameter int MAX_INFLIGHT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [XMM_IDX_W-1:0] cmd_xa,
  input  logic [XMM_IDX_W-1:0] cmd_xb,
  output logic [1:0]           src_a,
  output logic [1:0]           src_b,
  output logic [XMM_IDX_W-1:0] xs_idx_a,
  output logic [XMM_IDX_W-1:0] xs_idx_b,
  output logic                 fpu_issue,
  input  logic                 fpu_result_valid,
  input  logic [DATA_W-1:0]    fpu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data
);
  state_t                    r_state;
  logic [1:0]                r_op;
  logic [XMM_IDX_W-1:0]      r_xa, r_xb;
  logic [MAX_INFLIGHT_W-1:0] r_step, r_ret;
  logic [1:0]                r_src_a, r_src_b;
  logic [XMM_IDX_W-1:0]      r_idx_a, r_idx_b;
  logic                      r_issue, r_rsp_valid;
  logic [DATA_W-1:0]         r_rsp_data;
  logic                      w_accept, w_add, w_done, w_last;
  logic [MAX_INFLIGHT_W-1:0] w_ret_next, w_n, w_nstep;
  logic [1:0]                w_op;
  logic [XMM_IDX_W-1:0]      w_xa, w_xb, w_idx_a, w_idx_b;
  logic [DATA_W-1:0]         w_acc_next;
  assign cmd_ready  = (r_state == ST_IDLE) && !reset;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_add      = fpu_result_valid && (r_state == ST_ISSUE || r_state == ST_DRAIN);
  assign w_ret_next = r_ret + {{(MAX_INFLIGHT_W-1){1'b0}}, w_add};
  assign w_n        = op_steps(r_op);
  assign w_done     = w_ret_next == w_n;
  assign w_last     = (r_step + 1'b1) == w_n;
  // operand selects for the step issued next: step 0 of a new command, or the following step
  assign w_op       = w_accept ? cmd_op : r_op;
  assign w_xa       = w_accept ? cmd_xa : r_xa;
  assign w_xb       = w_accept ? cmd_xb : r_xb;
  assign w_nstep    = w_accept ? '0 : r_step + 1'b1;
  assign w_idx_a    = (w_op == OP_SUB && w_nstep == MAX_INFLIGHT_W'(1)) ? w_xb : w_xa + XMM_IDX_W'(w_nstep);
  assign w_idx_b    = w_xb + XMM_IDX_W'(w_nstep);
  assign src_a      = r_src_a;
  assign src_b      = r_src_b;
  assign xs_idx_a   = r_idx_a;
  assign xs_idx_b   = r_idx_b;
  assign fpu_issue  = r_issue;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  fpu_seq_acc #(.DATA_W(DATA_W)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_add  (w_add),
    .i_val  (fpu_result),
    .o_next (w_acc_next)
  );
  // sequencing FSM with registered issue, operand-select and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_xa        <= '0;
      r_xb        <= '0;
      r_step      <= '0;
      r_ret       <= '0;
      r_src_a     <= SRC_GPR;
      r_src_b     <= SRC_GPR;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_issue     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (w_accept) begin
            r_op    <= cmd_op;
            r_xa    <= cmd_xa;
            r_xb    <= cmd_xb;
            r_step  <= '0;
            r_ret   <= '0;
            r_issue <= 1'b1;
            r_src_a <= sel_a(w_op, w_nstep);
            r_src_b <= sel_b(w_op);
            r_idx_a <= w_idx_a;
            r_idx_b <= w_idx_b;
            r_state <= ST_ISSUE;
          end
        ST_ISSUE: begin
          r_ret <= w_ret_next;
          if (w_last) begin
            r_issue <= 1'b0;
            r_state <= w_done ? ST_RESP : ST_DRAIN;
            if (w_done) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_acc_next;
            end
          end else begin
            r_step  <= w_nstep;
            r_src_a <= sel_a(w_op, w_nstep);
            r_src_b <= sel_b(w_op);
            r_idx_a <= w_idx_a;
            r_idx_b <= w_idx_b;
          end
        end
        ST_DRAIN: begin
          r_ret <= w_ret_next;
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_acc_next;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP:
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: scoreboard bench with an FPU latency model and randomized macro-ops
module tb_fpu_op_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_xa = '0, cmd_xb = '0;
  logic [1:0]  src_a, src_b;
  logic [2:0]  xs_idx_a, xs_idx_b;
  logic        fpu_issue;
  logic        fpu_result_valid = 1'b0;
  logic [63:0] fpu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;

  fpu_op_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_xa(cmd_xa), .cmd_xb(cmd_xb),
    .src_a(src_a), .src_b(src_b), .xs_idx_a(xs_idx_a), .xs_idx_b(xs_idx_b),
    .fpu_issue(fpu_issue), .fpu_result_valid(fpu_result_valid), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sa, sb;
    logic [2:0] ia, ib;
    bit         ca, cb;
  } iss_t;

  iss_t        exp_iss[$];
  logic [63:0] exp_rsp[$];
  logic [63:0] prods[$];
  int          pend_due[$];
  logic [63:0] pend_val[$];
  int vectors = 0, errors = 0, n_issue = 0, cyc = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  bit spur = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nsteps(input logic [1:0] op);
    return op == 2'b10 ? 3 : op == 2'b11 ? 2 : 1;
  endfunction

  function automatic logic [63:0] acc_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
`ifdef FPU_SEQ_SAT_EN
    if (s[64] != s[63]) return s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return s[63:0];
  endfunction

  // FPU model: each issue returns its product after a random latency, in issue order
  always @(negedge clk) begin
    int d;
    cyc++;
    if (reset) begin
      pend_due.delete();
      pend_val.delete();
      prods.delete();
      fpu_result_valid = 1'b0;
      fpu_result = '0;
    end else begin
      if (fpu_issue) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend_due.push_back(d);
        pend_val.push_back(prods.size() != 0 ? prods.pop_front() : 64'h0);
      end
      if (pend_due.size() != 0 && pend_due[0] == cyc) begin
        void'(pend_due.pop_front());
        fpu_result_valid = 1'b1;
        fpu_result = pend_val.pop_front();
      end else if (spur && rsp_valid && !rsp_ready) begin
        fpu_result_valid = 1'b1;
        fpu_result = {$urandom, $urandom};
      end else begin
        fpu_result_valid = 1'b0;
      end
    end
  end

  // monitor: checks every issue and every presented response against the scoreboard
  always @(negedge clk) begin
    iss_t e;
    if (!reset) begin
      if (fpu_issue) begin
        n_issue++;
        if (exp_iss.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
        else begin
          e = exp_iss.pop_front();
          chk("src_a", 64'(src_a), 64'(e.sa));
          chk("src_b", 64'(src_b), 64'(e.sb));
          if (e.ca) chk("xs_idx_a", 64'(xs_idx_a), 64'(e.ia));
          if (e.cb) chk("xs_idx_b", 64'(xs_idx_b), 64'(e.ib));
        end
      end
      if (rsp_valid) begin
        chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          chk("rsp_data", rsp_data, exp_rsp[0]);
          if (rsp_ready) void'(exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic expect_cmd(input logic [1:0] op, input logic [2:0] xa, input logic [2:0] xb,
                            input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
    logic [63:0] p[3];
    logic [63:0] acc;
    iss_t e;
    p[0] = p0; p[1] = p1; p[2] = p2;
    acc = '0;
    for (int i = 0; i < nsteps(op); i++) begin
      case (op)
        2'b00: e = '{2'b10, 2'b10, xa, xb, 1, 1};
        2'b01: e = '{2'b00, 2'b01, 3'd0, 3'd0, 0, 0};
        2'b10: e = '{2'b10, 2'b10, 3'((int'(xa) + i) % 8), 3'((int'(xb) + i) % 8), 1, 1};
        default: e = '{i == 0 ? 2'b10 : 2'b11, 2'b01, i == 0 ? xa : xb, 3'd0, 1, 0};
      endcase
      exp_iss.push_back(e);
      prods.push_back(p[i]);
      acc = acc_add(acc, p[i]);
    end
    exp_rsp.push_back(acc);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] xa, input logic [2:0] xb);
    int t = 0;
    while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'd0, 64'd1);
    cmd_op = op; cmd_xa = xa; cmd_xb = xb; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int rdy, input bit sp);
    int t = 0;
    while (!rsp_valid && t < 80) begin @(posedge clk); #1; t++; end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    spur = sp;
    if (rdy > 0) begin
      cmd_valid = 1'b1;
      cmd_op = 2'($urandom);
      repeat (rdy) begin @(posedge clk); #1; end
    end
    cmd_valid = 1'b0;
    spur = 0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 64'({cmd_ready, rsp_valid, fpu_issue}), 64'b100);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] xa, input logic [2:0] xb,
                         input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                         input int rdy, input bit sp);
    expect_cmd(op, xa, xb, p0, p1, p2);
    send_cmd(op, xa, xb);
    finish_rsp(rdy, sp);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_issue_rsp"}, 64'({fpu_issue, rsp_valid}), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_src_idx"}, 64'({src_a, src_b, xs_idx_a, xs_idx_b}), 64'd0);
    exp_iss.delete();
    exp_rsp.delete();
    last_due = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, 64'({cmd_ready, rsp_valid, fpu_issue}), 64'b100);
  endtask

  initial begin
    int t, base;
    logic [1:0] op;
    @(posedge clk); #1;
    do_reset("reset");
    lat_min = 3; lat_max = 3;
    run_cmd(2'b00, 3'd2, 3'd5, 64'h10, 64'h0, 64'h0, 0, 0);
    lat_min = 1; lat_max = 1;
    run_cmd(2'b10, 3'd6, 3'd0, 64'd5, 64'd7, -64'sd2, 0, 0);
    lat_min = 1; lat_max = 4;
    run_cmd(2'b11, 3'd1, 3'd3, 64'd9, -64'sd4, 64'h0, 1, 0);
    run_cmd(2'b00, 3'd4, 3'd7, 64'h1234, 64'h0, 64'h0, 4, 1);
    expect_cmd(2'b10, 3'd3, 3'd4, 64'd1, 64'd2, 64'd3);
    base = n_issue;
    send_cmd(2'b10, 3'd3, 3'd4);
    t = 0;
    while (n_issue - base < 2 && t < 20) begin @(posedge clk); #1; t++; end
    do_reset("abort");
    run_cmd(2'b01, 3'd0, 3'd0, 64'h8001_0000_0000_0000, 64'h0, 64'h0, 0, 0);
    run_cmd(2'b10, 3'd7, 3'd7, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 2, 1);
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      lat_max = int'($urandom_range(4, 1));
      run_cmd(op, 3'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              64'($signed(32'($urandom))), int'($urandom_range(3, 0)), 1'($urandom));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("leftover_rsp", 64'(exp_rsp.size()), 64'd0);
    chk("leftover_iss", 64'(exp_iss.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
Sequences multi-step FPU macro-ops over the shared FPU operand-select path. It accepts one command at a time and, per step, drives the two operand source selects (general register, one, XMM, negated XMM) plus XMM read indices. It issues one FPU operation per cycle, counts and accumulates the returned Q-format results, and hands back a single 64-bit response. It sits between the decode/issue stage and the FPU operand muxes.

Parameters:
XMM_IDX_W, 3, XMM register index width (8 registers); index arithmetic wraps modulo 2**XMM_IDX_W
DATA_W, 64, FPU result / accumulator width (signed Q format)
MAX_INFLIGHT_W, 2, width of issued/returned counters (max 3 steps)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 MUL, 01 CVT, 10 DOT3, 11 SUB
cmd_xa  in  XMM_IDX_W  first XMM operand base index
cmd_xb  in  XMM_IDX_W  second XMM operand base index
src_a  out  2  operand A select: 00 GPR, 01 ONE, 10 XMM, 11 NEG XMM
src_b  out  2  operand B select, same encoding
xs_idx_a  out  XMM_IDX_W  XMM read index for operand A
xs_idx_b  out  XMM_IDX_W  XMM read index for operand B
fpu_issue  out  1  start one FPU multiply this cycle
fpu_result_valid  in  1  one FPU result returns this cycle
fpu_result  in  DATA_W  returned product
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  accumulated result

Behaviour:
- Clock clk; reset is synchronous and active-high. The FPU shares this reset and flushes its pipeline on it.
- Reset values: state IDLE, cmd_ready 0 while reset is high, fpu_issue 0, rsp_valid 0, rsp_data 0, src_a/src_b 00, xs_idx 0, counters 0, accumulator 0.
- States: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, the block latches op/xa/xb, clears the accumulator and counters, and moves to ISSUE.
- ISSUE: fpu_issue=1 every cycle with no stalls; step i=0..N-1; then moves to DRAIN after the last step. The first issue occurs in the cycle after acceptance.
  - MUL: N=1; A=XMM[xa], B=XMM[xb].
  - CVT: N=1; A=GPR, B=ONE.
  - DOT3: N=3; A=XMM[xa+i], B=XMM[xb+i]; index wraps (xa=7, i=1 -> 0).
  - SUB: N=2; step0 A=XMM[xa], B=ONE; step1 A=NEG XMM[xb], B=ONE.
- src and xs_idx outputs are registered and valid in the same cycle as fpu_issue. They hold their last value when fpu_issue=0.
- Every fpu_result_valid in ISSUE or DRAIN adds fpu_result to the accumulator (signed two's-complement add, wraps at DATA_W) and increments the returned count. Results may arrive during ISSUE for any latency >= 1.
- DRAIN: waits until returned == N, then rsp_data <= accumulator and the state moves to RESP. If the last result arrives in the last ISSUE cycle, ISSUE goes directly to RESP.
- RESP: rsp_valid=1 and rsp_data held stable until rsp_ready. The handshake cycle returns to IDLE. A new command is accepted at the earliest in the next cycle; there is no back-to-back overlap.
- fpu_result_valid in IDLE or RESP is ignored, with no state change.
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- Reset mid-operation aborts immediately and forces the reset values; the in-progress response is lost.

Optional Feature:
Macro FPU_SEQ_SAT_EN.
- Defined: the accumulator add saturates to signed DATA_W bounds, 0x7FFF_FFFF_FFFF_FFFF and 0x8000_0000_0000_0000.
- Undefined: the add wraps modulo 2**DATA_W.

Decomposition:
- Package fpu_seq_pkg: src codes (SRC_GPR=2'b00, SRC_ONE=2'b01, SRC_XMM=2'b10, SRC_NXMM=2'b11), op codes (OP_MUL, OP_CVT, OP_DOT3, OP_SUB), state enum, per-op step-count function.
- One sub-module, fpu_seq_acc: registered accumulator with clear, add-enable and the FPU_SEQ_SAT_EN saturation option.

Test Plan:
- Reset, then idle: cmd_ready=1 in the first cycle after reset deasserts; rsp_valid=0; fpu_issue=0.
- MUL xa=2 xb=5, model returns 0x10 after 3 cycles -> one issue with src 10/10, idx 2/5; rsp_data=0x10; FSM back to IDLE after rsp_ready.
- DOT3 xa=6 xb=0, model latency 1, products 5, 7, -2 -> idx_a sequence 6, 7, 0; idx_b 0, 1, 2; rsp_data=10.
- SUB xa=1 xb=3 -> step0 src_a=10 src_b=01; step1 src_a=11 src_b=01; returns 9 and -4 -> rsp_data=5.
- Backpressure: rsp_ready low 4 cycles -> rsp_data stable, cmd_ready=0, spurious fpu_result_valid ignored.
- Reset asserted mid-DOT3 after 2 issues -> all outputs at reset values next cycle; following CVT returning 0x8001000000000000 responds with exactly that value.
- Overflow: DOT3 with products 0x7FFF_FFFF_FFFF_FFFF, 1, 0.
  - Without FPU_SEQ_SAT_EN: rsp_data=0x8000_0000_0000_0000.
  - With FPU_SEQ_SAT_EN: rsp_data=0x7FFF_FFFF_FFFF_FFFF.
